dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares one byte-wide data memory between two 32-bit requesters: port 0 is the CPU load/store unit, port 1 is the DMA/debug loader.
- Arbitrates round-robin between the ports.
- Sequences each 32-bit word access as four big-endian byte beats against the memory.
- Sits between the requesters and the data RAM; it owns mem_we and mem_addr exclusively.

Parameters:
- ADDR_W, 8, byte-address width of the memory (memory depth = 2^ADDR_W bytes).
- BEATS, 4, byte beats per word; fixed at 4, not to be overridden.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write enable (1 write, 0 read); stable while req0 is high.
- addr0  in  32  port 0 byte address; bits [ADDR_W-1:0] used, rest ignored.
- wdata0  in  32  port 0 write word.
- ack0  out  1  one-cycle pulse: port 0 transaction complete.
- req1, we1, addr1, wdata1, ack1  (same as port 0, for port 1).
- rdata  out  32  read word; valid in the cycle ack0 or ack1 is high for a read.
- busy  out  1  high whenever state != IDLE.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_wdata  out  8  byte to memory.
- mem_we  out  1  byte write strobe; memory writes on the CLK edge where it is high.
- mem_rdata  in  8  byte from memory; asynchronous read of mem_addr, same cycle.

Behaviour:
- Reset (synchronous, dominates everything):
  - state=IDLE, beat=0, last_grant=1 (so port 0 wins first).
  - ack0=ack1=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- States: IDLE, XFER, DONE.
- IDLE:
  - If any req is high at the edge: select port, latch we, addr[ADDR_W-1:0] and wdata into internal registers, beat<=0, go to XFER.
  - Selection: the only requester; if both are high, the port != last_grant. last_grant updates to the selected port.
  - No req: stay in IDLE.
- XFER, one beat per cycle, beat 0..3:
  - mem_addr = (base + beat) mod 2^ADDR_W. Wrap-around is required: base 0xFF, beat 1 gives 0x00.
  - Write: mem_we=1, mem_wdata = word byte (3-beat), i.e. beat 0 = bits [31:24], beat 3 = bits [7:0].
  - Read: mem_we=0; at the edge, shift mem_rdata into the read register; beat 0 lands in bits [31:24].
  - After beat 3 go to DONE.
  - mem_we is 0 in every state other than XFER.
- DONE:
  - ack of the granted port = 1 for exactly this cycle.
  - For a read, rdata = assembled word.
  - Next state IDLE.
- rdata holds its value until the next read completes; writes do not change it.
- Latency: req sampled at edge E0; beats occupy cycles E0+1..E0+4; ack is high in cycle E0+5. 6 cycles per transaction including the IDLE sample.
- Request rules:
  - Inputs are latched at grant, so changes to we/addr/wdata after grant have no effect.
  - A req dropped mid-transaction does not abort: the transaction completes and ack still pulses.
  - A req still high in the IDLE cycle after DONE starts a new transaction; requesters drop req on seeing ack.
- Simultaneous continuous requests alternate strictly: 0,1,0,1.
- The non-granted port waits with ack low. No starvation: worst-case wait is one transaction.
- Misaligned addresses are legal; no alignment is forced.
- Reset mid-XFER: abort immediately and issue no ack. Bytes written on earlier edges stay in memory. The first request after reset goes to port 0.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE=2'd0, XFER=2'd1, DONE=2'd2).
  - BEATS=4.
  - byte-lane select function: beat -> bit slice [31-8*beat -: 8].
- One sub-module, dmem_rr_pick:
  - combinational 2-way round-robin selector.
  - inputs req0, req1, last_grant; outputs grant_valid, grant_id.
  - Everything else stays in the top-level FSM.

Test Plan:
- Reset: assert Reset 2 cycles with req0=1 -> all outputs 0, no mem_we. First grant after release is port 0.
- Write: port 0 writes 0x11223344 to addr 0x10 -> mem_we high 4 consecutive cycles at 0x10..0x13 with bytes 11,22,33,44. ack0 in cycle E0+5, ack1 never.
- Read: port 1 reads 0x10 -> mem_we stays 0, addresses 0x10..0x13 driven, ack1 with rdata=0x11223344. rdata unchanged by a later write.
- Contention: hold req0=req1=1 for 4 transactions, writes 0xA0A0A0A0 / 0xB1B1B1B1 to 0x20 / 0x40 -> grant order 0,1,0,1. Exactly one ack per DONE, busy high except IDLE cycles.
- Wrap: port 0 writes 0xAABBCCDD at 0xFE -> bytes AA@0xFE, BB@0xFF, CC@0x00, DD@0x01. A read at 0xFE returns 0xAABBCCDD.
- Reset mid-op: memory preset to 0; write 0xDEADBEEF at 0x30, assert Reset at beat 2 -> 0x30=DE, 0x31=AD, 0x32=0x33=00. No ack; state IDLE; the next port-1 request completes normally in 6 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory port arbiter
package dmem_pkg;

    localparam int BEATS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Big-endian lane order: beat 0 carries the most significant byte.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] beat);
        return word[31 - 8*int'(beat) -: 8];
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - combinational two-way round-robin selector
module dmem_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = (req0 && req1) ? ~last_grant : req1;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-port 32-bit requester arbiter over a byte-wide data RAM
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [31:0]       addr0,
    input  logic [31:0]       wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata1,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    state_t              state, state_next;
    logic [1:0]          beat;
    logic                last_grant;
    logic                gnt;
    logic                we_q;
    logic [ADDR_W-1:0]   base;
    logic [31:0]         wdata_q;
    logic [23:0]         shift_q;
    logic [31:0]         rdata_q;

    logic                grant_valid, grant_id;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic                in_xfer;
    logic                last_beat;

    logic                unused_addr_hi;
    assign unused_addr_hi = ^{addr0[31:ADDR_W], addr1[31:ADDR_W]};

    dmem_rr_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_we    = grant_id ? we1 : we0;
        sel_addr  = grant_id ? addr1[ADDR_W-1:0] : addr0[ADDR_W-1:0];
        sel_wdata = grant_id ? wdata1 : wdata0;
    end

    assign last_beat = (beat == 2'(BEATS - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = XFER;
            XFER:    if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset gates every output combinationally so an aborted beat never strobes the RAM.
    always_comb begin
        in_xfer   = !Reset && (state == XFER);
        busy      = !Reset && (state != IDLE);
        mem_we    = in_xfer && we_q;
        mem_addr  = in_xfer ? base + ADDR_W'(beat) : '0;
        mem_wdata = (in_xfer && we_q) ? byte_lane(wdata_q, beat) : 8'h00;
        ack0      = !Reset && (state == DONE) && !gnt;
        ack1      = !Reset && (state == DONE) && gnt;
        rdata     = Reset ? 32'h0 : rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            beat       <= 2'd0;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            we_q       <= 1'b0;
            base       <= '0;
            wdata_q    <= 32'h0;
            shift_q    <= 24'h0;
            rdata_q    <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gnt        <= grant_id;
                        last_grant <= grant_id;
                        we_q       <= sel_we;
                        base       <= sel_addr;
                        wdata_q    <= sel_wdata;
                        beat       <= 2'd0;
                    end
                end
                XFER: begin
                    beat <= beat + 2'd1;
                    if (!we_q) begin
                        shift_q <= {shift_q[15:0], mem_rdata};
                        if (last_beat) rdata_q <= {shift_q, mem_rdata};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench with transaction-level reference model
module tb_dmem_port_arbiter;

    logic        CLK;
    logic        Reset;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    bit   [7:0]  ram [256];

    int checks = 0;
    int errors = 0;

    // Reference model: transaction phase 0 = idle, 1..4 = byte beats, 5 = completion.
    int          ph;
    int          m_port;
    int          m_last;
    logic        m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    bit   [7:0]  ref_mem [256];

    int          active [2];

    dmem_port_arbiter #(.ADDR_W(8)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .req0      (req[0]),
        .we0       (we[0]),
        .addr0     (addr[0]),
        .wdata0    (wdata[0]),
        .ack0      (ack[0]),
        .req1      (req[1]),
        .we1       (we[1]),
        .addr1     (addr[1]),
        .wdata1    (wdata[1]),
        .ack1      (ack[1]),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_rdata = ram[mem_addr];
    always @(posedge CLK) if (mem_we) ram[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane_of(input logic [31:0] w, input int b);
        return 8'(w >> (8 * (3 - b)));
    endfunction

    // Predict the effect of the coming clock edge from the inputs now applied.
    task automatic model_edge();
        int p;
        if (Reset) begin
            ph = 0; m_last = 1; m_rdata = 32'h0;
        end else if (ph == 0) begin
            if (req[0] || req[1]) begin
                p = (req[0] && req[1]) ? 1 - m_last : (req[1] ? 1 : 0);
                m_port = p; m_last = p;
                m_we = we[p]; m_addr = 8'(addr[p]); m_wdata = wdata[p];
                ph = 1;
            end
        end else if (ph <= 4) begin
            if (m_we) ref_mem[8'(m_addr + 8'(ph - 1))] = lane_of(m_wdata, ph - 1);
            if (ph == 4 && !m_we)
                m_rdata = {ref_mem[m_addr], ref_mem[8'(m_addr + 8'd1)],
                           ref_mem[8'(m_addr + 8'd2)], ref_mem[8'(m_addr + 8'd3)]};
            ph++;
        end else begin
            ph = 0;
        end
    endtask

    task automatic cycle_check();
        bit xfer;
        if (Reset) begin
            check("rst_busy", 32'(busy), 0);
            check("rst_ack0", 32'(ack[0]), 0);
            check("rst_ack1", 32'(ack[1]), 0);
            check("rst_mem_we", 32'(mem_we), 0);
            check("rst_mem_addr", 32'(mem_addr), 0);
            check("rst_mem_wdata", 32'(mem_wdata), 0);
            check("rst_rdata", rdata, 0);
        end else begin
            xfer = (ph >= 1 && ph <= 4);
            check("busy", 32'(busy), 32'(ph != 0));
            check("ack0", 32'(ack[0]), 32'(ph == 5 && m_port == 0));
            check("ack1", 32'(ack[1]), 32'(ph == 5 && m_port == 1));
            check("mem_we", 32'(mem_we), 32'(xfer && m_we));
            if (xfer) begin
                check("mem_addr", 32'(mem_addr), 32'(8'(m_addr + 8'(ph - 1))));
                if (m_we) check("mem_wdata", 32'(mem_wdata), 32'(lane_of(m_wdata, ph - 1)));
            end
            check("rdata", rdata, m_rdata);
        end
    endtask

    task automatic tick();
        model_edge();
        @(negedge CLK);
        cycle_check();
    endtask

    task automatic run_txn(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ack[p] && lat < 20);
        check("ack_seen", 32'(ack[p]), 1);
        req[p] = 1'b0;
        tick();
    endtask

    initial begin
        int lat, n, k, diffs;
        ph = 0; m_port = 0; m_last = 1; m_we = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 0; we[p] = 0; addr[p] = 0; wdata[p] = 0; active[p] = 0;
        end

        // Reset held two cycles with a pending port-0 write.
        Reset = 1'b1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h11223344;
        tick();
        tick();
        check("reset_no_we", 32'(mem_we), 0);

        // Release with both ports requesting: port 0 must win first.
        Reset = 1'b0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; wdata[1] = 32'h0;
        n = 0;
        do begin tick(); n++; end while (!(ack[0] || ack[1]) && n < 20);
        check("first_grant_p0", 32'(ack[0]), 1);
        check("write_latency", n, 5);
        req[0] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!ack[1] && n < 20);
        check("read_ack1", 32'(ack[1]), 1);
        check("read_word", rdata, 32'h11223344);
        req[1] = 1'b0;
        tick();
        check("w_byte10", 32'(ram[8'h10]), 32'h11);
        check("w_byte11", 32'(ram[8'h11]), 32'h22);
        check("w_byte12", 32'(ram[8'h12]), 32'h33);
        check("w_byte13", 32'(ram[8'h13]), 32'h44);

        run_txn(1, 1'b1, 32'h80, 32'h55667788, lat);
        check("rdata_hold", rdata, 32'h11223344);

        // Continuous contention alternates strictly.
        req[0] = 1; we[0] = 1; addr[0] = 32'h20; wdata[0] = 32'hA0A0A0A0;
        req[1] = 1; we[1] = 1; addr[1] = 32'h40; wdata[1] = 32'hB1B1B1B1;
        n = 0; k = 0;
        while (k < 4 && n < 60) begin
            tick(); n++;
            if (ack[0] || ack[1]) begin
                check("rr_order", 32'(ack[1]), 32'(k % 2));
                k++;
            end
        end
        check("rr_count", k, 4);
        req[0] = 0; req[1] = 0;
        tick();
        check("rr_byte20", 32'(ram[8'h20]), 32'hA0);
        check("rr_byte43", 32'(ram[8'h43]), 32'hB1);

        // Address wrap past the top of memory.
        run_txn(0, 1'b1, 32'hFE, 32'hAABBCCDD, lat);
        check("wrap_FE", 32'(ram[8'hFE]), 32'hAA);
        check("wrap_FF", 32'(ram[8'hFF]), 32'hBB);
        check("wrap_00", 32'(ram[8'h00]), 32'hCC);
        check("wrap_01", 32'(ram[8'h01]), 32'hDD);
        run_txn(1, 1'b0, 32'h123456FE, 32'h0, lat);
        check("wrap_read", rdata, 32'hAABBCCDD);

        // Reset asserted during beat 2 of a write.
        req[0] = 1; we[0] = 1; addr[0] = 32'h30; wdata[0] = 32'hDEADBEEF;
        tick(); tick(); tick();
        check("abort_at_beat2", 32'(mem_addr), 32'h32);
        Reset = 1'b1;
        req[0] = 0;
        tick();
        Reset = 1'b0;
        check("abort_30", 32'(ram[8'h30]), 32'hDE);
        check("abort_31", 32'(ram[8'h31]), 32'hAD);
        check("abort_32", 32'(ram[8'h32]), 32'h00);
        check("abort_33", 32'(ram[8'h33]), 32'h00);
        run_txn(1, 1'b0, 32'h30, 32'h0, lat);
        check("post_reset_latency", lat, 5);
        check("post_reset_read", rdata, 32'hDEAD0000);

        // Randomized requesters with occasional resets.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                Reset = 1'b1;
                for (int p = 0; p < 2; p++) begin req[p] = 0; active[p] = 0; end
            end else begin
                Reset = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (active[p] != 0 && ack[p]) begin
                        req[p] = 0; active[p] = 0;
                    end else if (active[p] == 0 && $urandom_range(0, 2) == 0) begin
                        active[p] = 1; req[p] = 1;
                        we[p] = 1'($urandom_range(0, 1));
                        addr[p] = $urandom; wdata[p] = $urandom;
                    end else if (active[p] != 0 && ph != 0 && m_port == p) begin
                        if ($urandom_range(0, 3) == 0) begin
                            addr[p] = $urandom; wdata[p] = $urandom; we[p] = ~we[p];
                        end
                        if ($urandom_range(0, 5) == 0) req[p] = 0;
                    end
                end
            end
            tick();
        end
        Reset = 1'b0;
        req[0] = 0; req[1] = 0;
        for (int c = 0; c < 8; c++) tick();

        diffs = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != ref_mem[i]) diffs++;
        check("ram_image", diffs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
